dcache_lookup_port: RTL and testbench
=====================================

Name: dcache_lookup_port

Overview:
- Requester-side port controller for the ECC tag-compare/arbiter stage of the std data cache; drives one of its NR_PORTS request ports.
- Accepts single-word loads and stores from a core-side client and issues the all-way lookup request.
- Supplies the tag one cycle after grant and evaluates hit_way/rdata.
- On a store hit, issues the single-way byte-enabled write, then returns a one-cycle response.

Parameters:
- ADDR_WIDTH, 64, physical address width.
- DCACHE_SET_ASSOC, 8, number of ways.
- LINE_WIDTH, 128, cache line data bits, with LINE_WIDTH/64 words per line.
- TAG_WIDTH, 44, tag bits.
- INDEX_WIDTH, 12, index+offset bits (addr[INDEX_WIDTH-1:0]).
- BYTE_OFFSET, 4, log2(LINE_WIDTH/8).

Ports:
- clk_i in 1: clock.
- rst_ni in 1: asynchronous active-low reset.
- req_valid_i in 1: client request valid.
- req_ready_o out 1: accepting a request.
- req_we_i in 1: 1 = store, 0 = load.
- req_addr_i in ADDR_WIDTH: byte address; bits [2:0] are ignored.
- req_wdata_i in 64: store data.
- req_be_i in 8: store byte enables.
- rsp_valid_o out 1: one-cycle response pulse.
- rsp_hit_o out 1: lookup hit.
- rsp_err_o out 1: multi-way hit.
- rsp_rdata_o out 64: load word.
- cache_req_o out DCACHE_SET_ASSOC: per-way request.
- cache_gnt_i in 1: grant for this port.
- cache_addr_o out ADDR_WIDTH: index address, offset bits zero.
- cache_we_o out 1: write.
- cache_wdata_o out LINE_WIDTH: write line data.
- cache_wdirty_o out 1: dirty bit to write.
- cache_wvalid_o out 1: valid bit to write.
- cache_be_data_o out LINE_WIDTH/8: data byte enables.
- cache_be_tag_o out 1: tag write enable (always 0).
- cache_be_vldrty_o out DCACHE_SET_ASSOC: valid/dirty write enable per way.
- cache_tag_o out TAG_WIDTH: compare tag, valid the cycle after grant.
- cache_hit_way_i in DCACHE_SET_ASSOC: hit vector.
- cache_rdata_i in DCACHE_SET_ASSOC*LINE_WIDTH: decoded line data per way.

Behaviour:
- Address split:
  - tag = addr[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH].
  - index = addr[INDEX_WIDTH-1:BYTE_OFFSET].
  - word = addr[BYTE_OFFSET-1:3].
- Accept on req_valid_i & req_ready_o. Request fields are latched; inputs are don't-care afterwards.
- FSM states: IDLE, LOOKUP, COMPARE, WRITE, RESP.
- IDLE:
  - req_ready_o=1; all cache outputs 0.
  - On accept -> LOOKUP.
- LOOKUP:
  - cache_req_o = all ones; cache_addr_o = {index, BYTE_OFFSET zeros}, other bits 0; cache_we_o=0.
  - Held stable until cache_gnt_i; on grant -> COMPARE.
- COMPARE:
  - cache_req_o=0; cache_tag_o = latched tag.
  - Sample cache_hit_way_i and cache_rdata_i.
  - Popcount>1 -> RESP with err=1, hit=0.
  - Popcount=0 -> RESP with hit=0.
  - Hit with load, or store with req_be=0 -> RESP with hit=1; the load latches the selected way's word [word*64 +: 64].
  - Hit with store and req_be!=0 -> WRITE; latch the hit way.
- WRITE:
  - cache_req_o = latched one-hot hit way; cache_we_o=1; cache_addr_o as in LOOKUP.
  - cache_wdata_o = wdata replicated into every word slot.
  - cache_be_data_o = req_be shifted to byte offset word*8, 0 elsewhere.
  - cache_be_vldrty_o = hit way; cache_wvalid_o=1, cache_wdirty_o=1; cache_be_tag_o=0.
  - All write outputs held unchanged until cache_gnt_i. The arbiter withholds grant ≥1 cycle for partial-block read-modify-write.
  - On grant -> RESP with hit=1.
- RESP:
  - rsp_valid_o=1 for exactly one cycle with registered hit/err/rdata.
  - rsp_rdata_o is 0 for stores, misses and errors.
  - -> IDLE. Next accept is possible the following cycle; there is no response backpressure.
- Load-hit latency: accept at cycle N, rsp_valid_o at N+3 with immediate grant. Each grant-stall cycle adds 1.
- Reset values: all outputs 0 except req_ready_o=1 (state IDLE). Asynchronous reset mid-transaction aborts immediately; no write is issued after reset release.
- cache_req_o is never asserted in COMPARE or RESP.

Optional Feature:
- Macro DCACHE_LOOKUP_PERF_EN.
- When defined, adds outputs perf_hit_cnt_o (32) and perf_miss_cnt_o (32).
  - Hit counter increments on each RESP with hit=1; miss counter increments on each RESP with hit=0 & err=0.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When undefined, neither port nor counters exist and behaviour is otherwise identical.

Test Plan:
- Load hit: addr 0x0000_1238, way 3 hit, way-3 line = 0x1111..._AAAA_BBBB_CCCC_DDDD, grant immediate -> rsp_valid at accept+3, hit=1, rdata=upper word (word index 1), err=0.
- Load miss: hit_way=0 -> rsp hit=0, rdata=0, no WRITE-state cache_req_o.
- Store partial: addr 0x40, be=0x0F, data 0xDEADBEEF_CAFEF00D, hit way 0, grant withheld 2 cycles in WRITE -> cache_req_o=0x01, we=1, be_data=0x000F, be_vldrty=0x01, wdirty=1, outputs stable across stall; rsp hit=1 after grant.
- Multi-hit: hit_way=0x05 -> rsp err=1, hit=0, no write.
- Reset asserted during a WRITE stall -> all cache outputs 0 asynchronously, req_ready_o=1 after release, no rsp_valid.
- With DCACHE_LOOKUP_PERF_EN: 3 hits + 2 misses -> perf_hit_cnt_o=3, perf_miss_cnt_o=2; forced preload 0xFFFFFFFF + hit -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/dcache_lookup_port.sv
// Requester-side port controller: all-way tag lookup, hit/miss evaluation and
// single-way byte-enabled store write. `define DCACHE_LOOKUP_PERF_EN adds hit/miss counters.
module dcache_lookup_port #(
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned DCACHE_SET_ASSOC = 8,
    parameter int unsigned LINE_WIDTH       = 128,
    parameter int unsigned TAG_WIDTH        = 44,
    parameter int unsigned INDEX_WIDTH      = 12,
    parameter int unsigned BYTE_OFFSET      = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   req_valid_i,
    output logic                                   req_ready_o,
    input  logic                                   req_we_i,
    input  logic [ADDR_WIDTH-1:0]                  req_addr_i,
    input  logic [63:0]                            req_wdata_i,
    input  logic [7:0]                             req_be_i,
    output logic                                   rsp_valid_o,
    output logic                                   rsp_hit_o,
    output logic                                   rsp_err_o,
    output logic [63:0]                            rsp_rdata_o,
    output logic [DCACHE_SET_ASSOC-1:0]            cache_req_o,
    input  logic                                   cache_gnt_i,
    output logic [ADDR_WIDTH-1:0]                  cache_addr_o,
    output logic                                   cache_we_o,
    output logic [LINE_WIDTH-1:0]                  cache_wdata_o,
    output logic                                   cache_wdirty_o,
    output logic                                   cache_wvalid_o,
    output logic [LINE_WIDTH/8-1:0]                cache_be_data_o,
    output logic                                   cache_be_tag_o,
    output logic [DCACHE_SET_ASSOC-1:0]            cache_be_vldrty_o,
    output logic [TAG_WIDTH-1:0]                   cache_tag_o,
    input  logic [DCACHE_SET_ASSOC-1:0]            cache_hit_way_i,
    input  logic [DCACHE_SET_ASSOC*LINE_WIDTH-1:0] cache_rdata_i
`ifdef DCACHE_LOOKUP_PERF_EN
    ,
    output logic [31:0]                            perf_hit_cnt_o,
    output logic [31:0]                            perf_miss_cnt_o
`endif
);

    localparam int unsigned WORDS  = LINE_WIDTH / 64;
    localparam int unsigned WORD_W = BYTE_OFFSET - 3;
    localparam int unsigned IDX_W  = INDEX_WIDTH - BYTE_OFFSET;
    localparam int unsigned BE_W   = LINE_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(DCACHE_SET_ASSOC + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        WRITE,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [TAG_WIDTH-1:0]        tag_p0;
    logic [IDX_W-1:0]            index_p0;
    logic [WORD_W-1:0]           word_p0;
    logic                        we_p0;
    logic [63:0]                 wdata_p0;
    logic [7:0]                  be_p0;

    logic [DCACHE_SET_ASSOC-1:0] hit_way_p1;
    logic [63:0]                 rdata_p1;
    logic                        hit_p1;
    logic                        err_p1;

    logic [CNT_W-1:0]            hit_cnt;
    logic [LINE_WIDTH-1:0]       sel_line;
    logic [63:0]                 sel_word;
    logic                        multi_hit;
    logic                        single_hit;
    logic                        accept;
    logic                        unused_addr;

    assign accept      = (state_q == IDLE) && req_valid_i;
    assign unused_addr = ^{req_addr_i[ADDR_WIDTH-1:INDEX_WIDTH+TAG_WIDTH], req_addr_i[2:0]};

    // Ways are one-hot on a clean hit, so OR-ing the selected lines yields the hit line.
    always_comb begin
        hit_cnt  = '0;
        sel_line = '0;
        for (int w = 0; w < DCACHE_SET_ASSOC; w++) begin
            hit_cnt = hit_cnt + CNT_W'(cache_hit_way_i[w]);
            if (cache_hit_way_i[w]) begin
                sel_line = sel_line | cache_rdata_i[w*LINE_WIDTH +: LINE_WIDTH];
            end
        end
        sel_word = sel_line[{word_p0, 6'b0} +: 64];
    end

    assign multi_hit  = hit_cnt > CNT_W'(1);
    assign single_hit = (hit_cnt != '0) && !multi_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hit_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == COMPARE) begin
                hit_p1 <= single_hit;
                err_p1 <= multi_hit;
            end
        end
    end

    // Stage p0: request capture on accept
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag_p0   <= req_addr_i[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH];
            index_p0 <= req_addr_i[INDEX_WIDTH-1:BYTE_OFFSET];
            word_p0  <= req_addr_i[BYTE_OFFSET-1:3];
            we_p0    <= req_we_i;
            wdata_p0 <= req_wdata_i;
            be_p0    <= req_be_i;
        end
    end

    // Stage p1: compare results
    always_ff @(posedge clk_i) begin
        if (state_q == COMPARE) begin
            hit_way_p1 <= cache_hit_way_i;
            rdata_p1   <= (single_hit && !we_p0) ? sel_word : 64'd0;
        end
    end

    always_comb begin
        state_d           = state_q;
        req_ready_o       = 1'b0;
        rsp_valid_o       = 1'b0;
        cache_req_o       = '0;
        cache_addr_o      = '0;
        cache_we_o        = 1'b0;
        cache_wdata_o     = '0;
        cache_wdirty_o    = 1'b0;
        cache_wvalid_o    = 1'b0;
        cache_be_data_o   = '0;
        cache_be_tag_o    = 1'b0;
        cache_be_vldrty_o = '0;
        cache_tag_o       = '0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = LOOKUP;
            end
            LOOKUP: begin
                cache_req_o                              = '1;
                cache_addr_o[INDEX_WIDTH-1:BYTE_OFFSET] = index_p0;
                if (cache_gnt_i) state_d = COMPARE;
            end
            COMPARE: begin
                cache_tag_o = tag_p0;
                // A store with no enabled bytes has nothing to write back.
                state_d = (single_hit && we_p0 && (be_p0 != 8'd0)) ? WRITE : RESP;
            end
            WRITE: begin
                cache_req_o                              = hit_way_p1;
                cache_we_o                               = 1'b1;
                cache_addr_o[INDEX_WIDTH-1:BYTE_OFFSET] = index_p0;
                cache_wdata_o                            = {WORDS{wdata_p0}};
                cache_be_data_o                          = BE_W'(be_p0) << {word_p0, 3'b0};
                cache_be_vldrty_o                        = hit_way_p1;
                cache_wvalid_o                           = 1'b1;
                cache_wdirty_o                           = 1'b1;
                if (cache_gnt_i) state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_hit_o   = (state_q == RESP) && hit_p1;
    assign rsp_err_o   = (state_q == RESP) && err_p1;
    assign rsp_rdata_o = (state_q == RESP) ? rdata_p1 : 64'd0;

`ifdef DCACHE_LOOKUP_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] perf_hit_cnt_q;
    logic [31:0] perf_miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_hit_cnt_q  <= 32'd0;
            perf_miss_cnt_q <= 32'd0;
        end else if (state_q == RESP) begin
            if (hit_p1) perf_hit_cnt_q <= sat_inc(perf_hit_cnt_q);
            else if (!err_p1) perf_miss_cnt_q <= sat_inc(perf_miss_cnt_q);
        end
    end

    assign perf_hit_cnt_o  = perf_hit_cnt_q;
    assign perf_miss_cnt_o = perf_miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_lookup_port.sv
// Directed bench for dcache_lookup_port with a response scoreboard.
module tb_dcache_lookup_port;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [63:0]   req_addr, req_wdata;
    logic [7:0]    req_be;
    logic          rsp_valid, rsp_hit, rsp_err;
    logic [63:0]   rsp_rdata;
    logic [7:0]    cache_req;
    logic          cache_gnt;
    logic [63:0]   cache_addr;
    logic          cache_we;
    logic [127:0]  cache_wdata;
    logic          cache_wdirty, cache_wvalid;
    logic [15:0]   cache_be_data;
    logic          cache_be_tag;
    logic [7:0]    cache_be_vldrty;
    logic [43:0]   cache_tag;
    logic [7:0]    hit_way;
    logic [1023:0] rdata_all;
`ifdef DCACHE_LOOKUP_PERF_EN
    logic [31:0]   perf_hit, perf_miss;
`endif

    typedef struct packed {
        logic        hit;
        logic        err;
        logic [63:0] rdata;
    } rsp_t;

    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_hits = 0;
    int   exp_misses = 0;

    always #5 clk = ~clk;

    dcache_lookup_port dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_we_i         (req_we),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .req_be_i         (req_be),
        .rsp_valid_o      (rsp_valid),
        .rsp_hit_o        (rsp_hit),
        .rsp_err_o        (rsp_err),
        .rsp_rdata_o      (rsp_rdata),
        .cache_req_o      (cache_req),
        .cache_gnt_i      (cache_gnt),
        .cache_addr_o     (cache_addr),
        .cache_we_o       (cache_we),
        .cache_wdata_o    (cache_wdata),
        .cache_wdirty_o   (cache_wdirty),
        .cache_wvalid_o   (cache_wvalid),
        .cache_be_data_o  (cache_be_data),
        .cache_be_tag_o   (cache_be_tag),
        .cache_be_vldrty_o(cache_be_vldrty),
        .cache_tag_o      (cache_tag),
        .cache_hit_way_i  (hit_way),
        .cache_rdata_i    (rdata_all)
`ifdef DCACHE_LOOKUP_PERF_EN
        ,
        .perf_hit_cnt_o   (perf_hit),
        .perf_miss_cnt_o  (perf_miss)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    // Runs one request from the IDLE cycle to its response; called at edge+1.
    task automatic run_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] be, input logic [7:0] hw, input int stall,
                           input logic exp_hit, input logic exp_err, input logic [63:0] exp_rd,
                           input logic exp_write, input logic [15:0] exp_be_data, input int exp_lat);
        rsp_t        e, got_rsp;
        logic [63:0] exp_caddr;
        int          cyc, stall_left;
        logic        got, wrote;
        e.hit = exp_hit; e.err = exp_err; e.rdata = exp_rd;
        sb.push_back(e);
        if (exp_hit) exp_hits++;
        else if (!exp_err) exp_misses++;
        exp_caddr = {52'd0, addr[11:4], 4'd0};
        hit_way   = hw;
        cache_gnt = 1'b1;
        chk("ready_idle", 128'(req_ready), 128'(1));
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        cyc_step();
        req_valid = 1'b0; req_we = ~we;
        req_addr  = {$urandom, $urandom}; req_wdata = {$urandom, $urandom}; req_be = 8'($urandom);
        cyc = 1; got = 1'b0; wrote = 1'b0; stall_left = stall;
        while (!got && cyc < 30) begin
            if (cyc == 1) begin
                chk("lookup_req", 128'(cache_req), 128'(8'hFF));
                chk("lookup_addr", 128'(cache_addr), 128'(exp_caddr));
                chk("lookup_we", 128'(cache_we), 128'(0));
            end
            if (cyc == 2) begin
                chk("compare_req", 128'(cache_req), 128'(0));
                chk("compare_tag", 128'(cache_tag), 128'(addr[55:12]));
            end
            if (cache_we) begin
                wrote = 1'b1;
                chk("wr_req", 128'(cache_req), 128'(hw));
                chk("wr_addr", 128'(cache_addr), 128'(exp_caddr));
                chk("wr_wdata", cache_wdata, {wdata, wdata});
                chk("wr_be_data", 128'(cache_be_data), 128'(exp_be_data));
                chk("wr_be_vldrty", 128'(cache_be_vldrty), 128'(hw));
                chk("wr_flags", 128'({cache_wvalid, cache_wdirty, cache_be_tag}), 128'(3'b110));
                if (stall_left > 0) begin
                    cache_gnt = 1'b0;
                    stall_left--;
                end else begin
                    cache_gnt = 1'b1;
                end
            end
            if (rsp_valid) begin
                got = 1'b1;
                chk("latency", 128'(cyc), 128'(exp_lat));
                chk("resp_no_req", 128'(cache_req), 128'(0));
                if (sb.size() == 0) begin
                    chk("sb_empty", 128'(0), 128'(1));
                end else begin
                    got_rsp = sb.pop_front();
                    chk("rsp_hit", 128'(rsp_hit), 128'(got_rsp.hit));
                    chk("rsp_err", 128'(rsp_err), 128'(got_rsp.err));
                    chk("rsp_rdata", 128'(rsp_rdata), 128'(got_rsp.rdata));
                end
            end else begin
                cyc_step();
                cyc++;
            end
        end
        if (!got) chk("rsp_timeout", 128'(0), 128'(1));
        chk("write_issued", 128'(wrote), 128'(exp_write));
        cache_gnt = 1'b1;
        cyc_step();
        chk("rsp_one_cycle", 128'(rsp_valid), 128'(0));
    endtask

    initial begin
        logic seen_rsp, seen_we;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; cache_gnt = 1'b0; hit_way = '0;
        for (int w = 0; w < 8; w++) rdata_all[w*128 +: 128] = {16{8'(w) ^ 8'h5A}};
        rdata_all[3*128 +: 128] = {64'h1111_1111_1111_1111, 64'hAAAA_BBBB_CCCC_DDDD};
        cyc_step();
        cyc_step();
        chk("rst_ready", 128'(req_ready), 128'(1));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_cache_req", 128'(cache_req), 128'(0));
        chk("rst_cache_we", 128'(cache_we), 128'(0));
        rst_n = 1'b1;
        cyc_step();

        run_txn(1'b0, 64'h1238, 64'h0, 8'h00, 8'h08, 0, 1'b1, 1'b0, 64'h1111_1111_1111_1111, 1'b0, 16'h0, 3);
        run_txn(1'b0, 64'h2000_0008, 64'h0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 64'h0, 1'b0, 16'h0, 3);
        run_txn(1'b1, 64'h40, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 8'h01, 2, 1'b1, 1'b0, 64'h0, 1'b1, 16'h000F, 6);
        run_txn(1'b0, 64'h80, 64'h0, 8'h00, 8'h05, 0, 1'b0, 1'b1, 64'h0, 1'b0, 16'h0, 3);
        run_txn(1'b1, 64'h100, 64'h1234, 8'h00, 8'h02, 0, 1'b1, 1'b0, 64'h0, 1'b0, 16'h0, 3);
        run_txn(1'b1, 64'h48, 64'h0123_4567_89AB_CDEF, 8'hF0, 8'h80, 0, 1'b1, 1'b0, 64'h0, 1'b1, 16'hF000, 4);
        run_txn(1'b0, 64'hFFF0, 64'h0, 8'h00, 8'h80, 0, 1'b1, 1'b0, 64'h5D5D_5D5D_5D5D_5D5D, 1'b0, 16'h0, 3);
        run_txn(1'b1, 64'h300, 64'h55, 8'hFF, 8'h00, 0, 1'b0, 1'b0, 64'h0, 1'b0, 16'h0, 3);

        // Reset during a stalled write
        hit_way = 8'h01; cache_gnt = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h40; req_wdata = 64'h77; req_be = 8'h0F;
        cyc_step();
        req_valid = 1'b0;
        cyc_step();
        cyc_step();
        chk("rstw_in_write", 128'(cache_we), 128'(1));
        cache_gnt = 1'b0;
        cyc_step();
        #3 rst_n = 1'b0;
        #1;
        chk("rstw_req", 128'(cache_req), 128'(0));
        chk("rstw_we", 128'(cache_we), 128'(0));
        chk("rstw_be", 128'({cache_be_data, cache_be_vldrty}), 128'(0));
        chk("rstw_flags", 128'({cache_wvalid, cache_wdirty, cache_be_tag}), 128'(0));
        chk("rstw_addr_data", {cache_addr, cache_wdata[63:0]}, 128'(0));
        chk("rstw_ready", 128'(req_ready), 128'(1));
        exp_hits = 0; exp_misses = 0;
        cyc_step();
        rst_n = 1'b1; cache_gnt = 1'b1;
        seen_rsp = 1'b0; seen_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc_step();
            seen_rsp |= rsp_valid;
            seen_we  |= cache_we;
        end
        chk("post_rst_no_rsp", 128'(seen_rsp), 128'(0));
        chk("post_rst_no_write", 128'(seen_we), 128'(0));
        chk("post_rst_ready", 128'(req_ready), 128'(1));

        run_txn(1'b0, 64'h1238, 64'h0, 8'h00, 8'h08, 0, 1'b1, 1'b0, 64'h1111_1111_1111_1111, 1'b0, 16'h0, 3);
        run_txn(1'b0, 64'h500, 64'h0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 64'h0, 1'b0, 16'h0, 3);
        run_txn(1'b1, 64'h48, 64'hA5A5, 8'h03, 8'h10, 1, 1'b1, 1'b0, 64'h0, 1'b1, 16'h0300, 5);
        run_txn(1'b0, 64'h80, 64'h0, 8'h00, 8'h05, 0, 1'b0, 1'b1, 64'h0, 1'b0, 16'h0, 3);
        run_txn(1'b1, 64'h600, 64'h1, 8'h01, 8'h00, 0, 1'b0, 1'b0, 64'h0, 1'b0, 16'h0, 3);
        run_txn(1'b0, 64'hFFF0, 64'h0, 8'h00, 8'h80, 0, 1'b1, 1'b0, 64'h5D5D_5D5D_5D5D_5D5D, 1'b0, 16'h0, 3);
        chk("sb_drained", 128'(sb.size()), 128'(0));

`ifdef DCACHE_LOOKUP_PERF_EN
        chk("perf_hits", 128'(perf_hit), 128'(exp_hits));
        chk("perf_misses", 128'(perf_miss), 128'(exp_misses));
        dut.perf_hit_cnt_q = 32'hFFFF_FFFF;
        cyc_step();
        run_txn(1'b0, 64'h1238, 64'h0, 8'h00, 8'h08, 0, 1'b1, 1'b0, 64'h1111_1111_1111_1111, 1'b0, 16'h0, 3);
        chk("perf_hit_sat", 128'(perf_hit), 128'(32'hFFFF_FFFF));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
